// File: rtl/a2f_pkg.sv
// Shared constants and helpers for the A2F frame packer: header layout and
// saturating counter arithmetic.
package a2f_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int SAMPLE_WIDTH = 16;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int HDR_MAGIC_MSB = 31;
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_OVF_BIT   = 23;
  localparam int HDR_SEQ_MSB   = 15;
  localparam int HDR_SEQ_LSB   = 0;

  function automatic logic [DATA_WIDTH-1:0] make_header(input logic ovf, input logic [15:0] seq);
    logic [DATA_WIDTH-1:0] h;
    h = '0;
    h[HDR_MAGIC_MSB:HDR_MAGIC_LSB] = HDR_MAGIC;
    h[HDR_OVF_BIT]                 = ovf;
    h[HDR_SEQ_MSB:HDR_SEQ_LSB]     = seq;
    return h;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/a2f_frame_packer_if.sv
// Sample input stream plus FT600-FSM facing FIFO read port and status.
interface a2f_frame_packer_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_AW      = 9
);
  logic                    enable;
  logic                    in_valid;
  logic [SAMPLE_WIDTH-1:0] in_sample;
  logic                    wr_req;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    wr_available;
  logic [FIFO_AW:0]        fill_level;
  logic [15:0]             overflow_cnt;
  logic                    underflow;

  modport master (
    output enable, in_valid, in_sample, wr_req,
    input  wdata, wr_available, fill_level, overflow_cnt, underflow
  );

  modport slave (
    input  enable, in_valid, in_sample, wr_req,
    output wdata, wr_available, fill_level, overflow_cnt, underflow
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; pointers carry a wrap bit so
// full/empty/count come straight from the pointer pair.
module sync_fifo_fwft #(
  parameter int DW = 32,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head word is forced to zero while empty so wdata reads 0 out of reset.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/a2f_frame_packer.sv
// Packs 16-bit IQ samples two per word, prefixes each frame with a
// sequence/overflow header and buffers the words for the FT600 bridge.
module a2f_frame_packer #(
  parameter int SAMPLE_WIDTH = a2f_pkg::SAMPLE_WIDTH,
  parameter int DATA_WIDTH   = a2f_pkg::DATA_WIDTH,
  parameter int FIFO_AW      = 9,
  parameter int FRAME_WORDS  = 255
) (
  input logic            clk,
  input logic            reset_n,
  a2f_frame_packer_if.slave bus
);
  import a2f_pkg::*;

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_V   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] TWO_V     = (FIFO_AW+1)'(2);
  localparam logic [15:0]      LAST_WORD = 16'(FRAME_WORDS - 1);

  logic [FIFO_AW:0]        count, free;
  logic                    fifo_empty, fifo_full;
  logic                    push;
  logic [DATA_WIDTH-1:0]   din, dout;

  logic                    half, half_n;
  logic [SAMPLE_WIDTH-1:0] held, held_n;
  logic [15:0]             word_cnt, word_cnt_n;
  logic [15:0]             seq, seq_n;
  logic                    ovf_pend, ovf_pend_n;
  logic [15:0]             ovf_cnt, ovf_cnt_n;
  logic                    underflow;

  // Room is judged on the registered fill only; a same-cycle pop earns no credit.
  assign free = DEPTH_V - count;

  always_comb begin
    half_n     = half;
    held_n     = held;
    word_cnt_n = word_cnt;
    seq_n      = seq;
    ovf_pend_n = ovf_pend;
    ovf_cnt_n  = ovf_cnt;
    push       = 1'b0;
    din        = '0;

    if (!bus.enable) begin
      half_n     = 1'b0;
      word_cnt_n = '0;
    end else if (bus.in_valid) begin
      if (!half) begin
        if (word_cnt == '0) begin
          // Header and its first payload word are reserved together.
          if (free >= TWO_V) begin
            push       = 1'b1;
            din        = make_header(ovf_pend, seq);
            held_n     = bus.in_sample;
            half_n     = 1'b1;
            ovf_pend_n = 1'b0;
            seq_n      = seq + 16'd1;
          end else begin
            ovf_pend_n = 1'b1;
            ovf_cnt_n  = sat_add16(ovf_cnt, 2'd1);
          end
        end else begin
          held_n = bus.in_sample;
          half_n = 1'b1;
        end
      end else begin
        half_n = 1'b0;
        if (!fifo_full) begin
          push       = 1'b1;
          din        = {held, bus.in_sample};
          word_cnt_n = (word_cnt == LAST_WORD) ? 16'd0 : word_cnt + 16'd1;
        end else begin
          ovf_pend_n = 1'b1;
          ovf_cnt_n  = sat_add16(ovf_cnt, 2'd2);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half     <= 1'b0;
      held     <= '0;
      word_cnt <= '0;
      seq      <= '0;
      ovf_pend <= 1'b0;
      ovf_cnt  <= '0;
    end else begin
      half     <= half_n;
      held     <= held_n;
      word_cnt <= word_cnt_n;
      seq      <= seq_n;
      ovf_pend <= ovf_pend_n;
      ovf_cnt  <= ovf_cnt_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      underflow <= 1'b0;
    else if (bus.wr_req && fifo_empty) underflow <= 1'b1;
  end

  sync_fifo_fwft #(
    .DW (DATA_WIDTH),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (din),
    .pop     (bus.wr_req),
    .dout    (dout),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (count)
  );

  assign bus.wdata        = dout;
  assign bus.wr_available = ~fifo_empty;
  assign bus.fill_level   = count;
  assign bus.overflow_cnt = ovf_cnt;
  assign bus.underflow    = underflow;

endmodule
